bias_vec: RTL and testbench

//  NUM_COLS-wide bias stage that sits between the systolic array column outputs and the activation stage.
//  - Forward: adds a per-column fixed-point bias to each systolic output, with saturation.
//  - Biases are double-buffered: the shadow bank loads while the active bank is in use.
//  - Backward: passes systolic deltas straight through and accumulates them into per-column bias gradients.

---
 rtl/bias_pkg.sv | 52 +++++
 rtl/bias_lane.sv | 96 +++++++++
 rtl/bias_vec.sv | 88 ++++++++
 tb/tb_bias_vec.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// -----------------------------------------------------------------------------
// bias_pkg
// Shared widths and saturating helpers for the bias stage.
//   - Default widths for the column count, data/bias, fraction and accumulator.
//   - sat_trunc(x, w): clamps a wide signed value into a w-bit signed range.
//   - sat_add(a, b, w): sum of two wide signed values clamped to w bits.
// Both helpers work on MAX_W-bit signed operands so that one function serves
// every width. Callers sign-extend into MAX_W and take the low w bits of .val.
// -----------------------------------------------------------------------------
package bias_pkg;

    localparam int NUM_COLS_DEF = 4;
    localparam int DATA_W_DEF   = 16;
    localparam int FRAC_W_DEF   = 8;
    localparam int ACC_W_DEF    = 24;

    // Working width of the helpers; must exceed ACC_W + 1.
    localparam int MAX_W = 64;

    localparam logic signed [MAX_W-1:0] ONE_W = 1;

    typedef struct packed {
        logic                    ovf;
        logic signed [MAX_W-1:0] val;
    } sat_res_t;

    function automatic sat_res_t sat_trunc(input logic signed [MAX_W-1:0] x,
                                           input int                      w);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        sat_res_t                r;
        hi    = (ONE_W <<< (w - 1)) - ONE_W;
        lo    = -hi - ONE_W;
        r.ovf = 1'b0;
        r.val = x;
        if (x > hi) begin
            r.ovf = 1'b1;
            r.val = hi;
        end else if (x < lo) begin
            r.ovf = 1'b1;
            r.val = lo;
        end
        return r;
    endfunction

    function automatic sat_res_t sat_add(input logic signed [MAX_W-1:0] a,
                                         input logic signed [MAX_W-1:0] b,
                                         input int                      w);
        return sat_trunc(a + b, w);
    endfunction

endpackage

// File: rtl/bias_lane.sv
// -----------------------------------------------------------------------------
// bias_lane
// One column of the bias stage.
//   clk, rst       clock, async active-high reset (clears every register)
//   load, bias     write bias into the shadow bank
//   swap           copy shadow bank into the active bank
//   valid, sys     per-lane input valid and systolic data/delta
//   backward       1 = pass-through and accumulate gradient
//   grad_clear     zero the accumulator (wins over a same-cycle accumulate)
//   vld_p1         registered valid
//   data_p1        biased result (forward) or pass-through (backward)
//   scalar_p1      registered copy of the shadow bank
//   grad_p1        accumulator clamped to DATA_W
//   sat            combinational: a saturation event is being registered now
// -----------------------------------------------------------------------------
module bias_lane
    import bias_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] bias,
    input  logic              swap,
    input  logic              valid,
    input  logic [DATA_W-1:0] sys,
    input  logic              backward,
    input  logic              grad_clear,
    output logic              vld_p1,
    output logic [DATA_W-1:0] data_p1,
    output logic [DATA_W-1:0] scalar_p1,
    output logic [DATA_W-1:0] grad_p1,
    output logic              sat
);

    logic signed [DATA_W-1:0] shadow;
    logic signed [DATA_W-1:0] active;
    logic signed [ACC_W-1:0]  acc;

    logic signed [MAX_W-1:0]  sys_w;
    logic signed [MAX_W-1:0]  act_w;
    logic signed [MAX_W-1:0]  acc_w;
    sat_res_t                 fwd_res;
    sat_res_t                 acc_res;
    sat_res_t                 grad_res;

    always_comb begin
        sys_w    = {{(MAX_W-DATA_W){sys[DATA_W-1]}}, sys};
        act_w    = {{(MAX_W-DATA_W){active[DATA_W-1]}}, active};
        acc_w    = {{(MAX_W-ACC_W){acc[ACC_W-1]}}, acc};
        fwd_res  = sat_add(sys_w, act_w, DATA_W);
        acc_res  = sat_add(acc_w, sys_w, ACC_W);
        grad_res = sat_trunc(acc_w, DATA_W);
    end

    // After clamping, bits above the target width are only sign copies.
    logic unused_hi;
    assign unused_hi = ^{fwd_res.val[MAX_W-1:DATA_W], acc_res.val[MAX_W-1:ACC_W],
                         grad_res.val[MAX_W-1:DATA_W]};

    // An accumulate overflow only counts when the clear does not discard it.
    assign sat = (valid && !backward && fwd_res.ovf)
               || (valid && backward && !grad_clear && acc_res.ovf)
               || grad_res.ovf;

    // ---- stage p0 -> p1 ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            active    <= '0;
            acc       <= '0;
            scalar_p1 <= '0;
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            grad_p1   <= '0;
        end else begin
            scalar_p1 <= shadow;
            if (load)
                shadow <= bias;
            // Reads the pre-load shadow, so load+swap together moves the old value.
            if (swap)
                active <= shadow;
            vld_p1 <= valid;
            if (valid)
                data_p1 <= backward ? sys : fwd_res.val[DATA_W-1:0];
            if (grad_clear)
                acc <= '0;
            else if (backward && valid)
                acc <= acc_res.val[ACC_W-1:0];
            grad_p1 <= grad_res.val[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/bias_vec.sv
// -----------------------------------------------------------------------------
// bias_vec
// NUM_COLS-wide bias stage between the systolic array and the activation stage.
// Forward: adds a double-buffered per-column bias with saturation.
// Backward: passes deltas through and accumulates per-column bias gradients.
//   clk, rst          clock, async active-high reset
//   load_bias_in      write bias_scalar_in into the shadow bank
//   bias_scalar_in    per-lane bias, lane i at [i*DATA_W +: DATA_W]
//   bias_switch_in    copy shadow bank into active bank
//   bias_valid_in     per-lane input valid
//   bias_sys_data_in  systolic outputs (forward) / deltas (backward)
//   bias_backward     1 = backward mode
//   grad_clear_in     zero all accumulators and the saturation flag
//   bias_valid_out    per-lane output valid
//   bias_data_out     biased or passed-through data
//   bias_scalar_out   registered copy of the shadow bank
//   bias_grad_out     accumulators clamped to DATA_W
//   sat_flag_out      sticky saturation indicator
// -----------------------------------------------------------------------------
module bias_vec
    import bias_pkg::*;
#(
    parameter int NUM_COLS = NUM_COLS_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_bias_in,
    input  logic [NUM_COLS*DATA_W-1:0] bias_scalar_in,
    input  logic                       bias_switch_in,
    input  logic [NUM_COLS-1:0]        bias_valid_in,
    input  logic [NUM_COLS*DATA_W-1:0] bias_sys_data_in,
    input  logic                       bias_backward,
    input  logic                       grad_clear_in,
    output logic [NUM_COLS-1:0]        bias_valid_out,
    output logic [NUM_COLS*DATA_W-1:0] bias_data_out,
    output logic [NUM_COLS*DATA_W-1:0] bias_scalar_out,
    output logic [NUM_COLS*DATA_W-1:0] bias_grad_out,
    output logic                       sat_flag_out
);

    logic [NUM_COLS-1:0] lane_sat;

    // Fixed-point adds are aligned, so FRAC_W only bounds the legal space; an
    // illegal width combination builds an inert block instead of wrong math.
    if (ACC_W > DATA_W && FRAC_W < DATA_W && ACC_W < MAX_W - 1) begin : g_lanes
        for (genvar i = 0; i < NUM_COLS; i++) begin : g_lane
            bias_lane #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .load       (load_bias_in),
                .bias       (bias_scalar_in[i*DATA_W +: DATA_W]),
                .swap       (bias_switch_in),
                .valid      (bias_valid_in[i]),
                .sys        (bias_sys_data_in[i*DATA_W +: DATA_W]),
                .backward   (bias_backward),
                .grad_clear (grad_clear_in),
                .vld_p1     (bias_valid_out[i]),
                .data_p1    (bias_data_out[i*DATA_W +: DATA_W]),
                .scalar_p1  (bias_scalar_out[i*DATA_W +: DATA_W]),
                .grad_p1    (bias_grad_out[i*DATA_W +: DATA_W]),
                .sat        (lane_sat[i])
            );
        end
    end else begin : g_inert
        assign bias_valid_out  = '0;
        assign bias_data_out   = '0;
        assign bias_scalar_out = '0;
        assign bias_grad_out   = '0;
        assign lane_sat        = '0;
    end

    // ---- stage p0 -> p1: sticky flag aligned with the lane outputs ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_flag_out <= 1'b0;
        else if (grad_clear_in)
            sat_flag_out <= 1'b0;
        else if (|lane_sat)
            sat_flag_out <= 1'b1;
    end

endmodule

// File: tb/tb_bias_vec.sv
module tb_bias_vec;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 24;

    logic           clk = 1'b0;
    logic           rst;
    logic           load;
    logic [N*W-1:0] bias;
    logic           sw;
    logic [N-1:0]   vld;
    logic [N*W-1:0] sys;
    logic           bwd;
    logic           clr;
    logic [N-1:0]   vout;
    logic [N*W-1:0] dout;
    logic [N*W-1:0] sout;
    logic [N*W-1:0] gout;
    logic           satf;

    int checks = 0;
    int errors = 0;

    // Reference state: plain integers, one entry per lane.
    int           m_shadow[N];
    int           m_active[N];
    int           m_acc[N];
    int           m_data[N];
    int           m_grad[N];
    int           m_scal[N];
    logic [N-1:0] m_vld;
    logic         m_sat;

    typedef struct {
        logic        ld;
        logic [15:0] b0;
        logic        s_w;
        logic [3:0]  v;
        logic [15:0] s;
        logic        bw;
        logic        cl;
        int          lane;
        logic [15:0] e_data;
        logic [3:0]  e_vld;
        logic [15:0] e_grad;
        logic        e_sat;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    bias_vec #(
        .NUM_COLS (N),
        .DATA_W   (W),
        .FRAC_W   (8),
        .ACC_W    (AW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .load_bias_in     (load),
        .bias_scalar_in   (bias),
        .bias_switch_in   (sw),
        .bias_valid_in    (vld),
        .bias_sys_data_in (sys),
        .bias_backward    (bwd),
        .grad_clear_in    (clr),
        .bias_valid_out   (vout),
        .bias_data_out    (dout),
        .bias_scalar_out  (sout),
        .bias_grad_out    (gout),
        .sat_flag_out     (satf)
    );

    function automatic int clamp(input int x, input int w, output bit ovf);
        int hi;
        int lo;
        hi  = (1 << (w - 1)) - 1;
        lo  = -(1 << (w - 1));
        ovf = (x > hi) || (x < lo);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic int lane_of(input logic [N*W-1:0] v, input int i);
        logic signed [W-1:0] s;
        s = v[i*W +: W];
        return int'(s);
    endfunction

    function automatic vec_t mk(input logic ld, input logic [15:0] b0, input logic s_w,
                                input logic [3:0] v, input logic [15:0] s, input logic bw,
                                input logic cl, input int lane, input logic [15:0] e_data,
                                input logic [3:0] e_vld, input logic [15:0] e_grad,
                                input logic e_sat);
        vec_t t;
        t.ld = ld; t.b0 = b0; t.s_w = s_w; t.v = v; t.s = s; t.bw = bw; t.cl = cl;
        t.lane = lane; t.e_data = e_data; t.e_vld = e_vld; t.e_grad = e_grad; t.e_sat = e_sat;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_shadow[i] = 0; m_active[i] = 0; m_acc[i] = 0;
            m_data[i] = 0; m_grad[i] = 0; m_scal[i] = 0;
        end
        m_vld = '0;
        m_sat = 1'b0;
    endtask

    // One clock of the specified behaviour, using the inputs currently driven.
    task automatic model_step();
        bit evt;
        bit o;
        int sv;
        evt = 1'b0;
        for (int i = 0; i < N; i++) begin
            sv        = lane_of(sys, i);
            m_scal[i] = m_shadow[i];
            m_grad[i] = clamp(m_acc[i], W, o);
            evt |= o;
            m_vld[i]  = vld[i];
            if (vld[i]) begin
                if (bwd) m_data[i] = sv;
                else begin
                    m_data[i] = clamp(sv + m_active[i], W, o);
                    evt |= o;
                end
            end
            if (clr) m_acc[i] = 0;
            else if (bwd && vld[i]) begin
                m_acc[i] = clamp(m_acc[i] + sv, AW, o);
                evt |= o;
            end
            if (sw) m_active[i] = m_shadow[i];
            if (load) m_shadow[i] = lane_of(bias, i);
        end
        m_sat = clr ? 1'b0 : (m_sat | evt);
    endtask

    task automatic compare_all(input string tag);
        logic [N*W-1:0] ed;
        logic [N*W-1:0] es;
        logic [N*W-1:0] eg;
        for (int i = 0; i < N; i++) begin
            ed[i*W +: W] = W'(m_data[i]);
            es[i*W +: W] = W'(m_scal[i]);
            eg[i*W +: W] = W'(m_grad[i]);
        end
        chk({tag, "_valid"},  64'(vout), 64'(m_vld));
        chk({tag, "_data"},   64'(dout), 64'(ed));
        chk({tag, "_scalar"}, 64'(sout), 64'(es));
        chk({tag, "_grad"},   64'(gout), 64'(eg));
        chk({tag, "_sat"},    64'(satf), 64'(m_sat));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},  64'(vout), 64'd0);
        chk({tag, "_data"},   64'(dout), 64'd0);
        chk({tag, "_scalar"}, 64'(sout), 64'd0);
        chk({tag, "_grad"},   64'(gout), 64'd0);
        chk({tag, "_sat"},    64'(satf), 64'd0);
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        load = 1'b0; bias = '0; sw = 1'b0; vld = '0; sys = '0; bwd = 1'b0; clr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        #2 rst = 1'b0;
        cycle("rst_release");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            load = ($urandom_range(0, 3) == 0);
            bias = {$urandom, $urandom};
            sw   = ($urandom_range(0, 4) == 0);
            vld  = 4'($urandom);
            sys  = {$urandom, $urandom};
            bwd  = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end

        // Drive accumulators into ACC_W saturation in both directions.
        idle_inputs();
        bwd = 1'b1;
        clr = 1'b1;
        cycle("gsat_clr");
        clr = 1'b0;
        vld = '1;
        sys = {16'h8000, 16'h8000, 16'h7fff, 16'h7fff};
        repeat (300) cycle("gsat");
        vld = '0;
        cycle("gsat_hold");
        chk("gsat_pos",  64'(gout[15:0]),  64'h7fff);
        chk("gsat_neg",  64'(gout[47:32]), 64'h8000);
        chk("gsat_flag", 64'(satf),        64'd1);

        // Reset asserted asynchronously with traffic in flight.
        vld  = '1;
        bwd  = 1'b0;
        sys  = {$urandom, $urandom};
        load = 1'b1;
        bias = {$urandom, $urandom};
        sw   = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("rst_mid_hold");
        idle_inputs();
        #2 rst = 1'b0;
        cycle("rst_mid_release");

        // Directed sequences; bias loads touch lane 0 only, sys is replicated.
        //          ld  b0        sw  v        s         bw  cl  ln  e_data    e_vld    e_grad    e_sat
        tbl.push_back(mk(1, 16'h0100, 0, 4'b0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 4'b0000, 16'h0000, 0, 0, 0, 16'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0001, 16'h0080, 0, 0, 0, 16'h0180, 4'b0001, 16'h0000, 0));
        tbl.push_back(mk(1, 16'h0200, 1, 4'b0000, 16'h0000, 0, 0, 0, 16'h0180, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0001, 16'h0000, 0, 0, 0, 16'h0100, 4'b0001, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 4'b0000, 16'h0000, 0, 0, 0, 16'h0100, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0001, 16'h0000, 0, 0, 0, 16'h0200, 4'b0001, 16'h0000, 0));
        tbl.push_back(mk(1, 16'h7f00, 0, 4'b0000, 16'h0000, 0, 0, 0, 16'h0200, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 4'b0001, 16'h0200, 0, 0, 0, 16'h0400, 4'b0001, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0001, 16'h0200, 0, 0, 0, 16'h7fff, 4'b0001, 16'h0000, 1));
        tbl.push_back(mk(1, 16'h8000, 0, 4'b0000, 16'h0000, 0, 0, 0, 16'h7fff, 4'b0000, 16'h0000, 1));
        tbl.push_back(mk(0, 16'h0000, 1, 4'b0000, 16'h0000, 0, 0, 0, 16'h7fff, 4'b0000, 16'h0000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0001, 16'hff00, 0, 0, 0, 16'h8000, 4'b0001, 16'h0000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0001, 16'h0100, 0, 0, 0, 16'h8100, 4'b0001, 16'h0000, 1));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0000, 16'h0000, 1, 1, 2, 16'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0100, 16'h0100, 1, 0, 2, 16'h0100, 4'b0100, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0100, 16'h0100, 1, 0, 2, 16'h0100, 4'b0100, 16'h0100, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0100, 16'hff80, 1, 0, 2, 16'hff80, 4'b0100, 16'h0200, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0000, 16'h0000, 1, 0, 2, 16'hff80, 4'b0000, 16'h0180, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0100, 16'h0100, 1, 1, 2, 16'h0100, 4'b0100, 16'h0180, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0000, 16'h0000, 1, 0, 2, 16'h0100, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b1010, 16'h0123, 0, 0, 1, 16'h0123, 4'b1010, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0000, 16'h0000, 0, 0, 0, 16'h8100, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 0, 4'b0000, 16'h0000, 0, 0, 3, 16'h0123, 4'b0000, 16'h0000, 0));

        foreach (tbl[k]) begin
            load = tbl[k].ld;
            bias = {48'h0, tbl[k].b0};
            sw   = tbl[k].s_w;
            vld  = tbl[k].v;
            sys  = {4{tbl[k].s}};
            bwd  = tbl[k].bw;
            clr  = tbl[k].cl;
            cycle($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_data", k),  64'(dout[tbl[k].lane*W +: W]), 64'(tbl[k].e_data));
            chk($sformatf("vec%0d_valid", k), 64'(vout),                     64'(tbl[k].e_vld));
            chk($sformatf("vec%0d_grad", k),  64'(gout[tbl[k].lane*W +: W]), 64'(tbl[k].e_grad));
            chk($sformatf("vec%0d_sat", k),   64'(satf),                     64'(tbl[k].e_sat));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
